// File: rtl/soc_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_uart_tx_if
// Description : Memory-mapped bus bundle for the soc_uart_tx transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_uart_tx_if #(
    parameter int ADDR_W = 4
);
    logic              bus_en_i;
    logic              bus_we_i;
    logic [ADDR_W-1:0] bus_addr_i;
    logic [31:0]       bus_wdata_i;
    logic [31:0]       bus_rdata_o;

    modport master (
        output bus_en_i,
        output bus_we_i,
        output bus_addr_i,
        output bus_wdata_i,
        input  bus_rdata_o
    );

    modport slave (
        input  bus_en_i,
        input  bus_we_i,
        input  bus_addr_i,
        input  bus_wdata_i,
        output bus_rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/soc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : soc_uart_tx
// Description : Memory-mapped UART transmitter: byte FIFO, baud divider and
//               frame FSM. Define UART_TX_PARITY_EN for an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    soc_uart_tx_if.slave      bus,
    output logic              tx_o,
    output logic              irq_o
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = $clog2(CLK_DIV);

    localparam logic [ADDR_W-1:0]   c_addr_txdata = ADDR_W'(0);
    localparam logic [ADDR_W-1:0]   c_addr_status = ADDR_W'(4);
    localparam logic [c_cnt_w-1:0]  c_cnt_full    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_baud_w-1:0] c_baud_last   = c_baud_w'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_ovf;
    logic [31:0]         r_rdata;

    logic                w_wr_txdata;
    logic                w_wr_status;
    logic                w_rd;
    logic                w_full;
    logic                w_empty;
    logic                w_busy;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_baud_end;
    logic [3:0]          w_cnt_field;
    logic [31:0]         w_status;
    logic                w_unused_ok;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    assign w_wr_txdata = bus.bus_en_i & bus.bus_we_i & (bus.bus_addr_i == c_addr_txdata);
    assign w_wr_status = bus.bus_en_i & bus.bus_we_i & (bus.bus_addr_i == c_addr_status);
    assign w_rd        = bus.bus_en_i & ~bus.bus_we_i;

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != S_IDLE);

    // The FSM only takes a byte from the registered count, so a fresh push
    // into an empty FIFO is always popped on the following cycle.
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_push    = w_wr_txdata & (~w_full | w_pop);
    assign w_ovf_set = w_wr_txdata & w_full & ~w_pop;

    assign w_baud_end = (r_baud == c_baud_last);

    // Count field is 4 bits wide; deeper FIFOs saturate it at 15.
    generate
        if (c_cnt_w <= 4) begin : g_cnt_narrow
            assign w_cnt_field = 4'(r_count);
        end else begin : g_cnt_wide
            assign w_cnt_field = (r_count > c_cnt_w'(15)) ? 4'hF : r_count[3:0];
        end
    endgenerate

    assign w_status = {20'd0, w_cnt_field, 4'd0, r_ovf, w_busy, w_empty, w_full};

    assign w_unused_ok = &{1'b0, bus.bus_wdata_i[31:8]};

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.bus_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & bus.bus_wdata_i[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered read port; holds between reads
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= (bus.bus_addr_i == c_addr_status) ? w_status : 32'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            if (r_state != S_IDLE) begin
                r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= ^r_shift;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[r_bit + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_o            = r_tx;
    assign irq_o           = w_empty & ~w_busy;
    assign bus.bus_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_soc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_uart_tx
// Description : Randomised bench for soc_uart_tx with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CLK_DIV;

    logic clk;
    logic rst;
    logic tx_o;
    logic irq_o;

    soc_uart_tx_if #(.ADDR_W(ADDR_W)) bus_if ();

    soc_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if.slave),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: byte queue, frame countdown and the expected line levels
    logic [7:0]  m_q [$];
    logic        m_wave [$];
    int          m_busy_left;
    logic        m_ovf;
    logic        m_tx;
    logic [31:0] m_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_update();
        logic       rd, wr_tx, wr_st, pop, full;
        logic [7:0] b;
        if (rst) begin
            m_q.delete();
            m_wave.delete();
            m_busy_left = 0;
            m_ovf       = 1'b0;
            m_tx        = 1'b1;
            m_rdata     = 32'd0;
            return;
        end
        rd    = bus_if.bus_en_i && !bus_if.bus_we_i;
        wr_tx = bus_if.bus_en_i && bus_if.bus_we_i && bus_if.bus_addr_i == 4'h0;
        wr_st = bus_if.bus_en_i && bus_if.bus_we_i && bus_if.bus_addr_i == 4'h4;
        full  = (m_q.size() == FIFO_DEPTH);
        if (rd) begin
            if (bus_if.bus_addr_i == 4'h4)
                m_rdata = {20'd0, 4'(m_q.size()), 4'd0, m_ovf, (m_busy_left != 0),
                           (m_q.size() == 0), full};
            else
                m_rdata = 32'd0;
        end
        pop = (m_busy_left == 0) && (m_q.size() != 0);
        if (pop) begin
            b = m_q.pop_front();
            for (int i = 0; i < CLK_DIV; i++) m_wave.push_back(1'b0);
            for (int k = 0; k < 8; k++)
                for (int i = 0; i < CLK_DIV; i++) m_wave.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
            for (int i = 0; i < CLK_DIV; i++) m_wave.push_back(^b);
`endif
            for (int i = 0; i < CLK_DIV; i++) m_wave.push_back(1'b1);
            m_busy_left = FRAME;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end
        if (wr_tx) begin
            if (!full || pop) m_q.push_back(bus_if.bus_wdata_i[7:0]);
        end
        if (wr_tx && full && !pop) m_ovf = 1'b1;
        else if (wr_st && bus_if.bus_wdata_i[3]) m_ovf = 1'b0;
        m_tx = (m_wave.size() != 0) ? m_wave.pop_front() : 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_val("tx", {31'd0, tx_o}, {31'd0, m_tx});
        check_val("irq", {31'd0, irq_o}, {31'd0, (m_q.size() == 0 && m_busy_left == 0)});
        check_val("rdata", bus_if.bus_rdata_o, m_rdata);
    endtask

    task automatic bus_idle(input int n);
        bus_if.bus_en_i = 1'b0;
        bus_if.bus_we_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data);
        bus_if.bus_en_i    = 1'b1;
        bus_if.bus_we_i    = 1'b1;
        bus_if.bus_addr_i  = addr;
        bus_if.bus_wdata_i = data;
        step();
        bus_if.bus_en_i = 1'b0;
        bus_if.bus_we_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] addr);
        bus_if.bus_en_i   = 1'b1;
        bus_if.bus_we_i   = 1'b0;
        bus_if.bus_addr_i = addr;
        step();
        bus_if.bus_en_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && !(irq_o === 1'b1 && m_q.size() == 0 && m_busy_left == 0)) begin
            step();
            i++;
        end
        check_val("wait_idle", {31'd0, irq_o}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus_if.bus_en_i    = 1'b0;
        bus_if.bus_we_i    = 1'b0;
        bus_if.bus_addr_i  = '0;
        bus_if.bus_wdata_i = '0;

        bus_idle(3);
        rst = 1'b0;
        bus_idle(2);

        // Status and read latency on an idle block
        bus_rd(4'h4);
        check_val("status_idle", bus_if.bus_rdata_o, 32'h0000_0002);
        bus_idle(1);
        bus_rd(4'hC);
        check_val("read_unmapped", bus_if.bus_rdata_o, 32'd0);
        bus_rd(4'h0);

        // Single byte
        bus_wr(4'h0, 32'h0000_0055);
        wait_idle(200);

        // Back-to-back frames with status polling
        bus_wr(4'h0, 32'h0000_00A5);
        bus_wr(4'h0, 32'h0000_003C);
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            if (i % 8 == 0) bus_rd(4'h4);
            else bus_idle(1);
        end
        wait_idle(400);

        // Overflow: ten writes while the first frame is in flight
        for (int i = 0; i < 10; i++) bus_wr(4'h0, 32'(8'h10 + i));
        bus_rd(4'h4);
        check_val("ovf_status", bus_if.bus_rdata_o & 32'h0000_0F08, 32'h0000_0808);
        bus_wr(4'h4, 32'h0000_0008);
        bus_rd(4'h4);
        wait_idle(20 * FRAME);
        bus_rd(4'h4);

        // Reset during DATA bit 3 with bytes queued
        bus_wr(4'h0, 32'h0000_00C3);
        bus_wr(4'h0, 32'h0000_0011);
        bus_wr(4'h0, 32'h0000_0022);
        bus_wr(4'h0, 32'h0000_0033);
        bus_idle(4 * CLK_DIV + 1);
        rst = 1'b1;
        step();
        check_val("rst_tx_high", {31'd0, tx_o}, 32'd1);
        rst = 1'b0;
        bus_rd(4'h4);
        check_val("rst_status", bus_if.bus_rdata_o, 32'h0000_0002);
        bus_idle(2 * FRAME);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 99));
            if (op < 12) begin
                bus_wr(4'h0, $urandom);
            end else if (op < 22) begin
                bus_rd(4'h4);
            end else if (op < 27) begin
                bus_rd(4'($urandom_range(0, 15)));
            end else if (op < 31) begin
                bus_wr(4'h4, $urandom);
            end else if (op < 33) begin
                bus_wr(4'($urandom_range(0, 15)), $urandom);
            end else if (op == 33 && $urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                bus_idle(1);
            end
        end
        wait_idle(30 * FRAME);
        bus_rd(4'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
